// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution row scheduler family.
package conv_pkg;

    // Controller states: priming the 3-row window, then one START/WAIT/STORE
    // round per output row with a single-row refill in between.
    typedef enum logic [3:0] {
        S_IDLE,
        S_PRIME_RD,
        S_PRIME_CAP,
        S_START,
        S_WAIT,
        S_STORE,
        S_NEXT_RD,
        S_NEXT_CAP,
        S_FIN
    } sched_state_e;

    // Padded input row: D channels per element, W+2 columns.
    function automatic int row_w(input int idw, input int d, input int w);
        return idw * d * (w + 2);
    endfunction

    // One conv_top output row: K channels per element, W columns.
    function automatic int out_w(input int idw, input int w, input int k);
        return idw * w * k;
    endfunction

    localparam int ROW_W = row_w(8, 4, 12);
    localparam int OUT_W = out_w(8, 12, 4);

endpackage

// File: rtl/conv_row_window.sv
// Three-row sliding window: each load shifts row0<-row1<-row2<-new row.
module conv_row_window #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn_i,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_row,
    output logic [WIDTH-1:0] o_row0,
    output logic [WIDTH-1:0] o_row1,
    output logic [WIDTH-1:0] o_row2
);

    logic [WIDTH-1:0] r_row0, r_row1, r_row2;

    // Shift on load only; contents are otherwise frozen.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_row0 <= '0;
            r_row1 <= '0;
            r_row2 <= '0;
        end else if (i_ld) begin
            r_row0 <= r_row1;
            r_row1 <= r_row2;
            r_row2 <= i_row;
        end
    end

    assign o_row0 = r_row0;
    assign o_row1 = r_row1;
    assign o_row2 = r_row2;

endmodule

// File: rtl/conv_row_sched.sv
// conv_row_sched: drives conv_top over an H x W map one output row at a time,
// refilling a 3-row window from row memory and writing each result row out.
module conv_row_sched
    import conv_pkg::*;
#(
    parameter int D   = 4,
    parameter int H   = 12,
    parameter int W   = 12,
    parameter int K   = 4,
    parameter int IDW = 8,
    parameter int RAW = 5
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [RAW-1:0]           rd_addr_o,
    input  logic [IDW*D*(W+2)-1:0]   rd_data_i,
    output logic [IDW*D*(W+2)-1:0]   image0_o,
    output logic [IDW*D*(W+2)-1:0]   image1_o,
    output logic [IDW*D*(W+2)-1:0]   image2_o,
    output logic                     image_start_o,
    input  logic                     conv_done_i,
    input  logic [IDW*W*K-1:0]       conv_row_i,
    output logic                     wr_en_o,
    input  logic                     wr_ready_i,
    output logic [RAW-1:0]           wr_addr_o,
    output logic [IDW*W*K-1:0]       wr_data_o
);

    localparam int LROW_W = row_w(IDW, D, W);
    localparam int LOUT_W = out_w(IDW, W, K);
    localparam logic [RAW-1:0] LAST_ROW   = RAW'(H - 1);
    localparam logic [RAW-1:0] PRIME_LAST = RAW'(2);

    sched_state_e      r_state, w_next;
    logic [RAW-1:0]    r_fptr;
    logic [RAW-1:0]    r_row;
    logic              r_wr_en;
    logic [RAW-1:0]    r_wr_addr;
    logic [LOUT_W-1:0] r_wr_data;
    logic              w_ld;

    // State register.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state and Moore strobes; busy covers everything but IDLE so a
    // start arriving alongside done_o is still refused.
    always_comb begin
        w_next        = r_state;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        rd_en_o       = 1'b0;
        image_start_o = 1'b0;
        w_ld          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = S_PRIME_RD;
            end
            S_PRIME_RD: begin
                rd_en_o = 1'b1;
                w_next  = S_PRIME_CAP;
            end
            S_PRIME_CAP: begin
                w_ld   = 1'b1;
                w_next = (r_fptr == PRIME_LAST) ? S_START : S_PRIME_RD;
            end
            S_START: begin
                image_start_o = 1'b1;
                w_next        = S_WAIT;
            end
            S_WAIT: begin
                if (conv_done_i) w_next = S_STORE;
            end
            S_STORE: begin
                if (wr_ready_i) w_next = (r_row == LAST_ROW) ? S_FIN : S_NEXT_RD;
            end
            S_NEXT_RD: begin
                rd_en_o = 1'b1;
                w_next  = S_NEXT_CAP;
            end
            S_NEXT_CAP: begin
                w_ld   = 1'b1;
                w_next = S_START;
            end
            S_FIN: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Fetch pointer, row counter and the held write transfer.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fptr    <= '0;
            r_row     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_fptr <= '0;
                    r_row  <= '0;
                end
                S_PRIME_CAP, S_NEXT_CAP: r_fptr <= r_fptr + RAW'(1);
                S_WAIT: if (conv_done_i) begin
                    r_wr_data <= conv_row_i;
                    r_wr_addr <= r_row;
                    r_wr_en   <= 1'b1;
                end
                S_STORE: if (wr_ready_i) begin
                    r_wr_en <= 1'b0;
                    if (r_row != LAST_ROW) r_row <= r_row + RAW'(1);
                end
                default: ;
            endcase
        end
    end

    // Row data arrives the cycle after the read strobe, i.e. during *_CAP.
    conv_row_window #(.WIDTH(LROW_W)) u_window (
        .clk    (clk),
        .rstn_i (rstn_i),
        .i_ld   (w_ld),
        .i_row  (rd_data_i),
        .o_row0 (image0_o),
        .o_row1 (image1_o),
        .o_row2 (image2_o)
    );

    assign rd_addr_o = r_fptr;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;

endmodule

// File: tb/tb_conv_row_sched.sv
// Bench for conv_row_sched: row memory, conv_top and output-memory stand-ins,
// a negedge monitor collecting events, and per-scenario checking tasks.
module tb_conv_row_sched;

    localparam int D = 4, H = 12, W = 12, K = 4, IDW = 8, RAW = 5;
    localparam int ROW_W  = IDW * D * (W + 2);
    localparam int OUT_W  = IDW * W * K;
    localparam int NB_ROW = ROW_W / 8;
    localparam int NB_OUT = OUT_W / 8;

    logic clk = 1'b0;
    logic rstn_i = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- main DUT (H=12) ----------------
    logic             start_i = 1'b0;
    logic             busy_o, done_o, rd_en_o, image_start_o, wr_en_o;
    logic [RAW-1:0]   rd_addr_o, wr_addr_o;
    logic [ROW_W-1:0] rd_data_i = '0;
    logic [ROW_W-1:0] image0_o, image1_o, image2_o;
    logic             conv_done_i;
    logic [OUT_W-1:0] conv_row_i;
    logic             wr_ready_i;
    logic [OUT_W-1:0] wr_data_o;

    conv_row_sched #(.D(D), .H(H), .W(W), .K(K), .IDW(IDW), .RAW(RAW)) u_dut (
        .clk(clk), .rstn_i(rstn_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .image0_o(image0_o), .image1_o(image1_o), .image2_o(image2_o),
        .image_start_o(image_start_o), .conv_done_i(conv_done_i), .conv_row_i(conv_row_i),
        .wr_en_o(wr_en_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    // ---------------- H=1 DUT ----------------
    logic             start1 = 1'b0;
    logic             busy1, done1, rd_en1, istart1, wr_en1;
    logic [RAW-1:0]   rd_addr1, wr_addr1;
    logic [ROW_W-1:0] rd_data1 = '0;
    logic [ROW_W-1:0] img0_1, img1_1, img2_1;
    logic             cdone1 = 1'b0;
    logic [OUT_W-1:0] crow1 = '0;
    logic             wr_ready1 = 1'b1;
    logic [OUT_W-1:0] wr_data1;

    conv_row_sched #(.D(D), .H(1), .W(W), .K(K), .IDW(IDW), .RAW(RAW)) u_dut1 (
        .clk(clk), .rstn_i(rstn_i), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
        .image0_o(img0_1), .image1_o(img1_1), .image2_o(img2_1),
        .image_start_o(istart1), .conv_done_i(cdone1), .conv_row_i(crow1),
        .wr_en_o(wr_en1), .wr_ready_i(wr_ready1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1)
    );

    // ---------------- environment models ----------------
    logic [7:0] salt = 8'h00;
    int  conv_lat  = 10;
    bit  spur_en   = 1'b0;
    int  stall_row = -1;
    int  stall_len = 0;
    int  stall_pct = 0;

    // Row memory: padded row n holds byte (n + salt) everywhere; junk when not read.
    always @(posedge clk)
        rd_data_i <= rd_en_o ? {NB_ROW{8'(rd_addr_o) + salt}} : {NB_ROW{8'hCC}};

    always @(posedge clk)
        rd_data1 <= rd_en1 ? {NB_ROW{8'(rd_addr1) + 8'h40}} : {NB_ROW{8'hCC}};

    // conv_top stand-in: done conv_lat cycles after start; result bytes are the
    // sum of the first bytes of the three window rows at completion time.
    int               ccnt = 0;
    logic             mdone = 1'b0;
    logic [OUT_W-1:0] mrow = '0;
    always @(posedge clk) begin
        if (!rstn_i) begin
            ccnt  <= 0;
            mdone <= 1'b0;
        end else begin
            mdone <= 1'b0;
            if (image_start_o) ccnt <= conv_lat;
            else if (ccnt > 0) begin
                ccnt <= ccnt - 1;
                if (ccnt == 1) begin
                    mdone <= 1'b1;
                    mrow  <= {NB_OUT{image0_o[7:0] + image1_o[7:0] + image2_o[7:0]}};
                end
            end
        end
    end

    always @(posedge clk) begin
        cdone1 <= istart1;
        crow1  <= {NB_OUT{img0_1[7:0] + img1_1[7:0] + img2_1[7:0]}};
    end

    // Spurious completions during read/capture cycles carry junk data.
    logic prev_rd = 1'b0;
    always @(posedge clk) prev_rd <= rd_en_o;
    always_comb begin
        conv_done_i = mdone | (spur_en & (rd_en_o | prev_rd));
        conv_row_i  = mdone ? mrow : {NB_OUT{8'hEE}};
    end

    // Output memory: stalls stall_len cycles on stall_row, plus random stalls.
    int   scnt = 0;
    logic rbit = 1'b0;
    always @(posedge clk) begin
        scnt <= (wr_en_o && int'(wr_addr_o) == stall_row) ? scnt + 1 : 0;
        rbit <= (int'($urandom_range(0, 99)) < stall_pct);
    end
    always_comb
        wr_ready_i = !(wr_en_o && int'(wr_addr_o) == stall_row && scnt < stall_len) && !rbit;

    // ---------------- monitor ----------------
    bit               mon_clr = 1'b0;
    int               cyc = 0, acc_cyc = -1, first_start = -1;
    int               rd_log[$];
    logic [ROW_W-1:0] st0[$], st1[$], st2[$];
    int               wa_log[$];
    logic [OUT_W-1:0] wd_log[$];
    int               n_start = 0, n_done = 0, n_acc = 0;
    int               hold_err = 0, stab_err = 0, store_err = 0, busy_gap = 0;
    int               wr_cyc[32];
    bit               in_conv = 1'b0, act = 1'b0, p_pend = 1'b0;
    logic [ROW_W-1:0] sn0, sn1, sn2;
    logic [RAW-1:0]   p_addr;
    logic [OUT_W-1:0] p_data;

    // Observe the DUT between edges and log everything the checks need.
    always @(negedge clk) begin
        if (mon_clr) begin
            rd_log.delete(); st0.delete(); st1.delete(); st2.delete();
            wa_log.delete(); wd_log.delete();
            cyc <= 0; acc_cyc <= -1; first_start <= -1;
            n_start <= 0; n_done <= 0; n_acc <= 0;
            hold_err <= 0; stab_err <= 0; store_err <= 0; busy_gap <= 0;
            in_conv <= 1'b0; act <= 1'b0; p_pend <= 1'b0;
            for (int i = 0; i < 32; i++) wr_cyc[i] <= 0;
        end else begin
            cyc <= cyc + 1;
            if (start_i && !busy_o && rstn_i) begin
                n_acc <= n_acc + 1;
                act   <= 1'b1;
                if (acc_cyc < 0) acc_cyc <= cyc;
            end
            if (act && !busy_o) busy_gap <= busy_gap + 1;
            if (done_o) begin
                n_done <= n_done + 1;
                act    <= 1'b0;
            end
            if (rd_en_o) rd_log.push_back(int'(rd_addr_o));
            if (image_start_o) begin
                st0.push_back(image0_o); st1.push_back(image1_o); st2.push_back(image2_o);
                n_start <= n_start + 1;
                if (first_start < 0) first_start <= cyc;
                in_conv <= 1'b1;
                sn0 <= image0_o; sn1 <= image1_o; sn2 <= image2_o;
            end else if (in_conv && (image0_o !== sn0 || image1_o !== sn1 || image2_o !== sn2))
                stab_err <= stab_err + 1;
            if (wr_en_o) wr_cyc[wr_addr_o] <= wr_cyc[wr_addr_o] + 1;
            if (wr_en_o && wr_ready_i) begin
                wa_log.push_back(int'(wr_addr_o));
                wd_log.push_back(wr_data_o);
                in_conv <= 1'b0;
            end
            if (p_pend && (!wr_en_o || wr_addr_o !== p_addr || wr_data_o !== p_data))
                hold_err <= hold_err + 1;
            p_pend <= wr_en_o && !wr_ready_i;
            p_addr <= wr_addr_o;
            p_data <= wr_data_o;
            if (wr_en_o && (rd_en_o || image_start_o)) store_err <= store_err + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] row_byte(input int n);
        return 8'(n) + salt;
    endfunction

    function automatic logic [ROW_W-1:0] exp_row(input int n);
        return {NB_ROW{row_byte(n)}};
    endfunction

    function automatic logic [OUT_W-1:0] exp_out(input int r);
        return {NB_OUT{row_byte(r) + row_byte(r + 1) + row_byte(r + 2)}};
    endfunction

    // Mismatches against: padded rows 0..H+1 each fetched once, in order.
    function automatic int read_errs();
        int e = 0;
        if (rd_log.size() != H + 2) e++;
        foreach (rd_log[i]) if (rd_log[i] != i) e++;
        return e;
    endfunction

    // Mismatches against: start i sees padded rows i, i+1, i+2.
    function automatic int img_errs();
        int e = 0;
        if (st0.size() != H) e++;
        foreach (st0[i])
            if (st0[i] !== exp_row(i) || st1[i] !== exp_row(i + 1) || st2[i] !== exp_row(i + 2)) e++;
        return e;
    endfunction

    // Mismatches against: writes to rows 0..H-1 carrying that row's result.
    function automatic int wr_errs();
        int e = 0;
        if (wa_log.size() != H) e++;
        foreach (wa_log[i]) if (wa_log[i] != i || wd_log[i] !== exp_out(i)) e++;
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic mon_clear();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic run_pass(input int lat, input bit hold, output bit ok);
        conv_lat = lat;
        mon_clear();
        @(posedge clk); #1 start_i = 1'b1;
        if (!hold) begin
            @(posedge clk); #1 start_i = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int ones;
        rstn_i = 1'b1;
        #1 rstn_i = 1'b0;
        @(negedge clk);
        ones = $countones({busy_o, done_o, rd_en_o, image_start_o, wr_en_o, rd_addr_o, wr_addr_o,
                           image0_o, image1_o, image2_o, wr_data_o, busy1});
        n_tests++;
        if (ones !== 0) begin
            n_fail++;
            $display("FAIL reset_outputs: %0d output bits set, required 0", ones);
        end
        @(posedge clk); #1 rstn_i = 1'b1;
    endtask

    task automatic test_nominal();
        bit ok;
        int e;
        salt = 8'h00;
        run_pass(10, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL nominal_done: no done_o within bound"); end
        e = read_errs();
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL nominal_reads: %0d mismatches (%0d reads), required 0 (14 reads)", e, rd_log.size()); end
        n_tests++;
        if (n_start !== H) begin n_fail++; $display("FAIL nominal_starts: got %0d, required %0d", n_start, H); end
        e = img_errs();
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL nominal_window: %0d mismatches, required 0", e); end
        e = wr_errs();
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL nominal_writes: %0d mismatches (%0d writes), required 0", e, wa_log.size()); end
        n_tests++;
        if (n_done !== 1) begin n_fail++; $display("FAIL nominal_done_count: got %0d, required 1", n_done); end
        // Start is seen one negedge before its accepting edge; six edges later image_start shows.
        n_tests++;
        if (first_start - acc_cyc !== 7) begin
            n_fail++; $display("FAIL nominal_latency: got %0d cycles, required 6", first_start - acc_cyc - 1);
        end
        n_tests++;
        if (stab_err !== 0 || store_err !== 0) begin
            n_fail++; $display("FAIL nominal_stability: window changes %0d, read/start during store %0d, required 0", stab_err, store_err);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int e;
        salt = 8'($urandom);
        stall_row = 3; stall_len = 7;
        run_pass(int'($urandom_range(2, 12)), 1'b0, ok);
        stall_row = -1; stall_len = 0;
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL bp_done: no done_o within bound"); end
        n_tests++;
        if (wr_cyc[3] !== 8) begin n_fail++; $display("FAIL bp_stall_cycles: wr_en_o high %0d cycles on row 3, required 8", wr_cyc[3]); end
        n_tests++;
        if (hold_err !== 0 || store_err !== 0) begin
            n_fail++; $display("FAIL bp_hold: hold violations %0d, read/start while pending %0d, required 0", hold_err, store_err);
        end
        e = wr_errs();
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL bp_writes: %0d mismatches, required 0", e); end
    endtask

    task automatic test_spurious();
        bit ok;
        int e;
        salt = 8'($urandom);
        spur_en = 1'b1;
        run_pass(int'($urandom_range(3, 12)), 1'b0, ok);
        spur_en = 1'b0;
        n_tests++;
        if (!ok || wa_log.size() !== H) begin
            n_fail++; $display("FAIL spur_count: done %0d, writes %0d, required done and %0d writes", ok, wa_log.size(), H);
        end
        e = wr_errs() + img_errs();
        n_tests++;
        if (e !== 0) begin n_fail++; $display("FAIL spur_data: %0d mismatches, required 0", e); end
    endtask

    task automatic test_start_held();
        bit ok;
        salt = 8'($urandom);
        run_pass(5, 1'b1, ok);
        n_tests++;
        if (!ok || n_acc !== 1 || n_done !== 1 || busy_gap !== 0) begin
            n_fail++;
            $display("FAIL held_single_pass: done %0d accepts %0d dones %0d busy gaps %0d, required 1/1/1/0", ok, n_acc, n_done, busy_gap);
        end
        @(negedge clk); #1;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap: busy_o=%0b after done, required 0", busy_o); end
        @(negedge clk); #1;
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL held_restart: busy_o=%0b after idle, required 1", busy_o); end
        @(posedge clk); #1 start_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1'b1;
        end
        #1;
        n_tests++;
        if (!ok || n_done !== 2 || wa_log.size() !== 2 * H) begin
            n_fail++; $display("FAIL held_second_pass: dones %0d writes %0d, required 2 and %0d", n_done, wa_log.size(), 2 * H);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int e, ones;
        salt = 8'($urandom);
        conv_lat = 10;
        mon_clear();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int i = 0; i < 2000 && n_start < 6; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rstn_i = 1'b0;
        #1 ones = $countones({busy_o, done_o, rd_en_o, image_start_o, wr_en_o, rd_addr_o, wr_addr_o,
                              image0_o, image1_o, image2_o, wr_data_o});
        n_tests++;
        if (n_start !== 6 || ones !== 0) begin
            n_fail++; $display("FAIL reset_mid_clear: starts before reset %0d (required 6), %0d output bits set (required 0)", n_start, ones);
        end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        salt = 8'($urandom);
        run_pass(7, 1'b0, ok);
        e = read_errs() + img_errs() + wr_errs();
        n_tests++;
        if (!ok || e !== 0) begin n_fail++; $display("FAIL reset_mid_rerun: done %0d, %0d mismatches, required done and 0", ok, e); end
    endtask

    task automatic test_random();
        bit ok;
        int e;
        for (int p = 0; p < 4; p++) begin
            salt = 8'($urandom);
            stall_pct = 30;
            spur_en = 1'($urandom);
            run_pass(int'($urandom_range(1, 15)), 1'b0, ok);
            stall_pct = 0;
            spur_en = 1'b0;
            e = read_errs() + img_errs() + wr_errs();
            n_tests++;
            if (!ok || e !== 0 || n_done !== 1) begin
                n_fail++; $display("FAIL random_pass%0d: done %0d, %0d model mismatches, dones %0d", p, ok, e, n_done);
            end
            n_tests++;
            if (hold_err !== 0 || stab_err !== 0 || store_err !== 0) begin
                n_fail++; $display("FAIL random_hold%0d: hold %0d window %0d store %0d, required 0", p, hold_err, stab_err, store_err);
            end
        end
    endtask

    task automatic test_h1();
        int  rds[$];
        int  ns = 0, fs = -1, nw = 0, waddr = -1;
        bit  acc, dn = 1'b0;
        logic [OUT_W-1:0] wdat = '0;
        @(posedge clk); #1 start1 = 1'b1;
        @(negedge clk); acc = start1 && !busy1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int i = 1; i < 200 && !dn; i++) begin
            @(negedge clk);
            if (rd_en1) rds.push_back(int'(rd_addr1));
            if (istart1) begin ns++; if (fs < 0) fs = i; end
            if (wr_en1 && wr_ready1) begin nw++; waddr = int'(wr_addr1); wdat = wr_data1; end
            if (done1) dn = 1'b1;
        end
        n_tests++;
        if (!acc || !dn || rds.size() !== 3) begin
            n_fail++; $display("FAIL h1_pass: accepted %0d done %0d reads %0d, required 1/1/3", acc, dn, rds.size());
        end else begin
            n_tests++;
            if (rds[0] !== 0 || rds[1] !== 1 || rds[2] !== 2) begin
                n_fail++; $display("FAIL h1_read_addr: %0d,%0d,%0d, required 0,1,2", rds[0], rds[1], rds[2]);
            end
        end
        n_tests++;
        if (ns !== 1 || fs !== 7) begin
            n_fail++; $display("FAIL h1_start: %0d pulses, first after %0d cycles, required 1 after 6", ns, fs - 1);
        end
        n_tests++;
        if (nw !== 1 || waddr !== 0 || wdat !== {NB_OUT{8'hC3}}) begin
            n_fail++; $display("FAIL h1_write: %0d writes addr %0d byte %0h, required 1 write addr 0 byte c3", nw, waddr, wdat[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_spurious();
        test_start_held();
        test_reset_mid();
        test_random();
        test_h1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
